// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/writeback controller wrapped around the AP9 ALU.
// Holds enable_alu for the opcode's stage count, then captures m2/FR_out.
//
// Ports:
//   wire_clock, wire_reset_n      clock, async active-low reset
//   issue_valid/issue_ready       issue handshake
//   issue_opcode/rd/use_carry/dec instruction fields
//   issue_a, issue_b              operands
//   enable_alu,m3,m4,opCode,      registered ALU drive
//   useCarry,dec,FR_in
//   m2, FR_out                    ALU results
//   wb_valid,wb_we,wb_rd,wb_data  one-cycle register file writeback
//   fr_q                          architectural flag register
//   illegal                       pulse for an unsupported opcode
// Build option: ALU_SEQ_FLUSH_EN adds a post-reset ALU flush phase.
module alu_sequencer (
  input  logic        wire_clock,
  input  logic        wire_reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  issue_opcode,
  input  logic [2:0]  issue_rd,
  input  logic        issue_use_carry,
  input  logic        issue_dec,
  input  logic [15:0] issue_a,
  input  logic [15:0] issue_b,
  output logic        enable_alu,
  output logic [15:0] m3,
  output logic [15:0] m4,
  output logic [5:0]  opCode,
  output logic        useCarry,
  output logic        dec,
  output logic [15:0] FR_in,
  input  logic [15:0] m2,
  input  logic [15:0] FR_out,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic [15:0] fr_q,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_SEQ_FLUSH_EN
    ,
    S_FLUSH = 2'd3
`endif
  } state_t;

`ifdef ALU_SEQ_FLUSH_EN
  localparam state_t RST_STATE = S_FLUSH;
  logic [8:0] fcnt_q;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  localparam logic [5:0] OP_FLD = 6'b000110;
  localparam logic [5:0] OP_CMP = 6'b000101;
  localparam logic [5:0] OP_INC = 6'b100100;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100001;
  localparam logic [5:0] OP_MUL = 6'b100010;
  localparam logic [5:0] OP_DIV = 6'b100011;
  localparam logic [5:0] OP_MOD = 6'b100101;
  localparam logic [5:0] OP_AND = 6'b010010;
  localparam logic [5:0] OP_OR  = 6'b010011;
  localparam logic [5:0] OP_XOR = 6'b010100;
  localparam logic [5:0] OP_NOT = 6'b010101;

  state_t     state_q, state_n;
  logic [2:0] cnt_q;
  logic [2:0] n_q;
  logic [2:0] rd_q;
  logic       we_q;
  logic       ill_q;
  logic       accept;
  logic       capture;

  logic       is_n1, is_n2, is_n3;
  logic       is_divmod;
  logic       legal;
  logic [2:0] n_dec;
  logic       we_dec;

  assign accept  = issue_valid & issue_ready;
  assign capture = (state_q == S_RUN) & ~ill_q
                 & (cnt_q == n_q + 3'd1);

  assign is_n1 = (issue_opcode == OP_FLD)
               | (issue_opcode == OP_INC)
               | (issue_opcode == OP_CMP);
  assign is_n2 = (issue_opcode == OP_ADD)
               | (issue_opcode == OP_MUL)
               | (issue_opcode == OP_DIV)
               | (issue_opcode == OP_MOD)
               | (issue_opcode == OP_AND)
               | (issue_opcode == OP_OR)
               | (issue_opcode == OP_XOR)
               | (issue_opcode == OP_NOT);
  assign is_n3 = (issue_opcode == OP_SUB);

  assign is_divmod = (issue_opcode == OP_DIV)
                   | (issue_opcode == OP_MOD);

  // cmp and flag load only update flags; a zero
  // divisor leaves the destination untouched.
  assign we_dec = ~(issue_opcode == OP_CMP)
                & ~(issue_opcode == OP_FLD)
                & ~(is_divmod & (issue_b == 16'd0));

  always_comb begin
    n_dec = 3'd0;
    legal = 1'b0;
    unique case (1'b1)
      is_n1: begin
        n_dec = 3'd1;
        legal = 1'b1;
      end
      is_n2: begin
        n_dec = 3'd2;
        legal = 1'b1;
      end
      is_n3: begin
        n_dec = 3'd3;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) state_q <= RST_STATE;
    else               state_q <= state_n;
  end

  // Illegal ops also pass through RUN so the
  // pulse lands one cycle after acceptance.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (accept) state_n = S_RUN;
      S_RUN: begin
        if (ill_q || capture) state_n = S_DONE;
      end
      S_DONE: state_n = S_IDLE;
`ifdef ALU_SEQ_FLUSH_EN
      S_FLUSH: begin
        if (fcnt_q == 9'd259) state_n = S_IDLE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n) begin
      issue_ready <= 1'b0;
      enable_alu  <= 1'b0;
      m3          <= '0;
      m4          <= '0;
      opCode      <= '0;
      useCarry    <= 1'b0;
      dec         <= 1'b0;
      FR_in       <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      fr_q        <= '0;
      illegal     <= 1'b0;
      cnt_q       <= '0;
      n_q         <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      ill_q       <= 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
      fcnt_q      <= '0;
`endif
    end else begin
      issue_ready <= (state_n == S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            m3       <= issue_a;
            m4       <= issue_b;
            opCode   <= issue_opcode;
            useCarry <= issue_use_carry;
            dec      <= issue_dec;
            FR_in    <= (issue_opcode == OP_FLD)
                      ? issue_a : fr_q;
            rd_q     <= issue_rd;
            we_q     <= we_dec;
            n_q      <= n_dec;
            ill_q    <= ~legal;
            cnt_q    <= 3'd0;
            enable_alu <= legal;
          end else begin
            FR_in <= fr_q;
          end
        end
        S_RUN: begin
          if (ill_q) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            illegal  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (capture) begin
              enable_alu <= 1'b0;
              wb_data    <= m2;
              fr_q       <= FR_out;
              FR_in      <= FR_out;
              wb_rd      <= rd_q;
              wb_we      <= we_q;
              wb_valid   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          illegal  <= 1'b0;
        end
`ifdef ALU_SEQ_FLUSH_EN
        // Park the ALU with a long flag-load of zero,
        // then drop enable for one cycle before IDLE.
        S_FLUSH: begin
          if (fcnt_q < 9'd258) begin
            enable_alu <= 1'b1;
            opCode     <= OP_FLD;
            FR_in      <= '0;
          end else begin
            enable_alu <= 1'b0;
          end
          if (fcnt_q != 9'd259) fcnt_q <= fcnt_q + 9'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer
// against a stub ALU that only yields results once staged.
module tb_alu_sequencer;

  logic        wire_clock = 1'b0;
  logic        wire_reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_opcode;
  logic [2:0]  issue_rd;
  logic        issue_use_carry;
  logic        issue_dec;
  logic [15:0] issue_a;
  logic [15:0] issue_b;
  logic        enable_alu;
  logic [15:0] m3;
  logic [15:0] m4;
  logic [5:0]  opCode;
  logic        useCarry;
  logic        dec;
  logic [15:0] FR_in;
  logic [15:0] m2;
  logic [15:0] FR_out;
  logic        wb_valid;
  logic        wb_we;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [15:0] fr_q;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_fr;
  logic [15:0] res_m2;
  logic [15:0] res_fr;
  int          res_n;
  logic [4:0]  acnt;

  alu_sequencer dut (
    .wire_clock      (wire_clock),
    .wire_reset_n    (wire_reset_n),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_opcode    (issue_opcode),
    .issue_rd        (issue_rd),
    .issue_use_carry (issue_use_carry),
    .issue_dec       (issue_dec),
    .issue_a         (issue_a),
    .issue_b         (issue_b),
    .enable_alu      (enable_alu),
    .m3              (m3),
    .m4              (m4),
    .opCode          (opCode),
    .useCarry        (useCarry),
    .dec             (dec),
    .FR_in           (FR_in),
    .m2              (m2),
    .FR_out          (FR_out),
    .wb_valid        (wb_valid),
    .wb_we           (wb_we),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .fr_q            (fr_q),
    .illegal         (illegal)
  );

  always #5 wire_clock = ~wire_clock;

  // Stub ALU: results are valid only after stage N.
  always @(posedge wire_clock or negedge wire_reset_n) begin
    if (!wire_reset_n)   acnt <= '0;
    else if (!enable_alu) acnt <= '0;
    else if (acnt != 5'd31) acnt <= acnt + 5'd1;
  end

  assign m2 = (int'(acnt) >= res_n + 1)
            ? res_m2 : 16'hDEAD;
  assign FR_out = (int'(acnt) >= res_n + 1)
                ? res_fr : 16'hBEEF;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input logic [5:0]  opc,
                       input logic [2:0]  rd,
                       input logic        uc,
                       input logic        dc,
                       input logic [15:0] a,
                       input logic [15:0] b);
    int g = 0;
    @(negedge wire_clock);
    while (!issue_ready && g < 400) begin
      @(negedge wire_clock);
      g++;
    end
    check("issue_ready", 32'(issue_ready), 1);
    issue_opcode    = opc;
    issue_rd        = rd;
    issue_use_carry = uc;
    issue_dec       = dc;
    issue_a         = a;
    issue_b         = b;
    issue_valid     = 1'b1;
    @(posedge wire_clock);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic run_op(input string       tag,
                        input logic [5:0]  opc,
                        input logic [2:0]  rd,
                        input logic        uc,
                        input logic        dc,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] rm2,
                        input logic [15:0] rfr,
                        input int          n,
                        input logic        we);
    int lat;
    logic [15:0] efrin;
    efrin  = (opc == 6'b000110) ? a : exp_fr;
    res_m2 = rm2;
    res_fr = rfr;
    res_n  = n;
    issue(opc, rd, uc, dc, a, b);
    check({tag, ".en"}, 32'(enable_alu), 1);
    check({tag, ".m3"}, 32'(m3), 32'(a));
    check({tag, ".m4"}, 32'(m4), 32'(b));
    check({tag, ".op"}, 32'(opCode), 32'(opc));
    check({tag, ".uc"}, 32'(useCarry), 32'(uc));
    check({tag, ".frin"}, 32'(FR_in), 32'(efrin));
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge wire_clock);
      #1;
      if (wb_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(n + 2));
    check({tag, ".data"}, 32'(wb_data), 32'(rm2));
    check({tag, ".we"}, 32'(wb_we), 32'(we));
    check({tag, ".rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".fr"}, 32'(fr_q), 32'(rfr));
    check({tag, ".enoff"}, 32'(enable_alu), 0);
    exp_fr = rfr;
    @(posedge wire_clock);
    #1;
    check({tag, ".wbclr"}, 32'(wb_valid), 0);
    check({tag, ".rdy"}, 32'(issue_ready), 1);
  endtask

  task automatic wait_ready(output int low,
                            output int wbv);
    low = 0;
    wbv = 0;
    do begin
      @(posedge wire_clock);
      #1;
      if (wb_valid) wbv++;
      if (!issue_ready) low++;
    end while (!issue_ready && low < 400);
  endtask

  initial begin
    int low;
    int wbv;
`ifdef ALU_SEQ_FLUSH_EN
    int exp_low = 259;
`else
    int exp_low = 0;
`endif
    wire_reset_n    = 1'b0;
    issue_valid     = 1'b0;
    issue_opcode    = '0;
    issue_rd        = '0;
    issue_use_carry = 1'b0;
    issue_dec       = 1'b0;
    issue_a         = '0;
    issue_b         = '0;
    res_m2          = '0;
    res_fr          = '0;
    res_n           = 0;
    exp_fr          = '0;

    #12;
    check("rst.en", 32'(enable_alu), 0);
    check("rst.rdy", 32'(issue_ready), 0);
    check("rst.wbv", 32'(wb_valid), 0);
    check("rst.fr", 32'(fr_q), 0);
    check("rst.ill", 32'(illegal), 0);
    check("rst.op", 32'(opCode), 0);
    @(negedge wire_clock);
    wire_reset_n = 1'b1;
    wait_ready(low, wbv);
    check("boot.low", 32'(low), 32'(exp_low));

    run_op("add", 6'h20, 3'd2, 0, 0,
           16'h0003, 16'h0005,
           16'h0008, 16'h0000, 2, 1);
    run_op("addov", 6'h20, 3'd1, 0, 0,
           16'hFFFF, 16'h0001,
           16'h0000, 16'h1800, 2, 1);
    check("addov.c", 32'(fr_q[12:11]), 32'h3);
    run_op("addc", 6'h20, 3'd1, 1, 0,
           16'h0001, 16'h0001,
           16'h0003, 16'h0000, 2, 1);
    run_op("subneg", 6'h21, 3'd3, 0, 0,
           16'h0003, 16'h0005,
           16'h0000, 16'h0040, 3, 1);
    run_op("sub", 6'h21, 3'd3, 0, 0,
           16'h0009, 16'h0004,
           16'h0005, 16'h0000, 3, 1);
    run_op("div0", 6'h23, 3'd4, 0, 0,
           16'h0007, 16'h0000,
           16'h0000, 16'h0200, 2, 0);
    run_op("div", 6'h23, 3'd4, 0, 0,
           16'h0007, 16'h0002,
           16'h0003, 16'h0000, 2, 1);
    run_op("mod", 6'h25, 3'd5, 0, 0,
           16'h0007, 16'h0002,
           16'h0001, 16'h0000, 2, 1);
    run_op("mod0", 6'h25, 3'd5, 0, 0,
           16'h0007, 16'h0000,
           16'h0000, 16'h0200, 2, 0);
    run_op("cmp", 6'h05, 3'd6, 0, 0,
           16'h0005, 16'h0009,
           16'h0000, 16'h4000, 1, 0);
    check("cmp.fl", 32'(fr_q[15:13]), 32'h2);
    run_op("fld", 6'h06, 3'd0, 0, 0,
           16'h00A5, 16'h0000,
           16'h0000, 16'h00A5, 1, 0);
    run_op("dec", 6'h24, 3'd7, 0, 1,
           16'h0010, 16'h0000,
           16'h000F, 16'h0000, 1, 1);
    run_op("and", 6'h12, 3'd2, 0, 0,
           16'hF0F0, 16'h3C3C,
           16'h3030, 16'h0000, 2, 1);

    issue(6'h3F, 3'd1, 0, 0, 16'h1234, 16'h5678);
    check("ill.en0", 32'(enable_alu), 0);
    @(posedge wire_clock);
    #1;
    check("ill.pulse", 32'(illegal), 1);
    check("ill.wbv", 32'(wb_valid), 1);
    check("ill.we", 32'(wb_we), 0);
    check("ill.en1", 32'(enable_alu), 0);
    @(posedge wire_clock);
    #1;
    check("ill.clr", 32'(illegal), 0);
    check("ill.rdy", 32'(issue_ready), 1);
    check("ill.fr", 32'(fr_q), 32'(exp_fr));

    res_m2 = 16'h000C;
    res_fr = 16'h0000;
    res_n  = 2;
    issue(6'h22, 3'd3, 0, 0, 16'h0003, 16'h0004);
    @(posedge wire_clock);
    #1;
    check("mrst.en", 32'(enable_alu), 1);
    #2;
    wire_reset_n = 1'b0;
    #1;
    check("mrst.enoff", 32'(enable_alu), 0);
    check("mrst.wbv", 32'(wb_valid), 0);
    check("mrst.m3", 32'(m3), 0);
    exp_fr = '0;
    @(negedge wire_clock);
    wire_reset_n = 1'b1;
    wait_ready(low, wbv);
    check("mrst.low", 32'(low), 32'(exp_low));
    for (int k = 0; k < 6; k++) begin
      @(posedge wire_clock);
      #1;
      if (wb_valid) wbv++;
    end
    check("mrst.nowb", 32'(wbv), 0);
    run_op("add2", 6'h20, 3'd1, 0, 0,
           16'h0002, 16'h0002,
           16'h0004, 16'h0000, 2, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
